// File: rtl/cycle_sequencer.sv
// Multicycle state-code sequencer (fetch/prep/exec) with run/step/stop control,
// HALT detection, memory wait states, PC breakpoint and saturating debug counters.
// Outputs are decoded from the registered state; requests act on the next rising edge.
module cycle_sequencer #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              stop_req,
  input  logic              sm_en,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [1:0]        sm,
  output logic              running,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PREP  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  state_t state_nxt;

  // step_mode: 1 = single instruction, 0 = free run
  logic step_mode;
  logic step_mode_nxt;
  logic stop_pending;
  logic stop_pending_nxt;
  // first_fetch masks the breakpoint so a restart at the breakpoint address proceeds
  logic first_fetch;
  logic first_fetch_nxt;
  logic bp_hit_nxt;
  logic instr_done;
  logic bp_match;

  assign bp_match = bp_en && !first_fetch && (pc == bp_addr);

  // State decode for the controller and the debug panel
  always_comb begin
    sm      = 2'b11;
    running = 1'b0;
    halted  = 1'b0;
    case (state)
      ST_FETCH: begin sm = 2'b00; running = 1'b1; end
      ST_PREP:  begin sm = 2'b01; running = 1'b1; end
      ST_EXEC:  begin sm = 2'b10; running = 1'b1; end
      ST_HALT:  halted = 1'b1;
      default:  sm = 2'b11;
    endcase
  end

  // Next-state and control-flag decisions
  always_comb begin
    state_nxt        = state;
    step_mode_nxt    = step_mode;
    stop_pending_nxt = stop_pending;
    first_fetch_nxt  = first_fetch;
    bp_hit_nxt       = bp_hit;
    instr_done       = 1'b0;

    // A stop request is only remembered while an instruction is in flight
    if (running && stop_req) begin
      stop_pending_nxt = 1'b1;
    end

    case (state)
      ST_STOP: begin
        if (step_req || run_req) begin
          state_nxt        = ST_FETCH;
          step_mode_nxt    = step_req;
          stop_pending_nxt = 1'b0;
          first_fetch_nxt  = 1'b1;
          bp_hit_nxt       = 1'b0;
        end
      end
      ST_FETCH: begin
        if (bp_match) begin
          // Stop before the fetch is performed
          state_nxt  = ST_STOP;
          bp_hit_nxt = 1'b1;
        end else if (mem_ready) begin
          state_nxt       = ST_PREP;
          first_fetch_nxt = 1'b0;
        end
      end
      ST_PREP: begin
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (!sm_en) begin
          // HALT instruction counts as executed, memory wait is irrelevant
          state_nxt  = ST_HALT;
          instr_done = 1'b1;
        end else if (mem_ready) begin
          instr_done = 1'b1;
          if (step_mode || stop_pending || stop_req) begin
            state_nxt = ST_STOP;
          end else begin
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_STOP;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STOP;
    end else begin
      state <= state_nxt;
    end
  end

  // Control flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_mode    <= 1'b0;
      stop_pending <= 1'b0;
      first_fetch  <= 1'b0;
      bp_hit       <= 1'b0;
    end else begin
      step_mode    <= step_mode_nxt;
      stop_pending <= stop_pending_nxt;
      first_fetch  <= first_fetch_nxt;
      bp_hit       <= bp_hit_nxt;
    end
  end

  // Saturating cycle and instruction counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (running && (cycle_cnt != CNT_MAX)) begin
        cycle_cnt <= cycle_cnt + CNT_ONE;
      end
      if (instr_done && (instr_cnt != CNT_MAX)) begin
        instr_cnt <= instr_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: directed scenarios plus a randomized
// run against a cycle-level reference model. A 4-bit-counter copy of the design
// shares all inputs to exercise counter saturation.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_req = 1'b0;
  logic       step_req = 1'b0;
  logic       stop_req = 1'b0;
  logic       sm_en = 1'b1;
  logic       mem_ready = 1'b1;
  logic [7:0] pc = 8'd0;
  logic       bp_en = 1'b0;
  logic [7:0] bp_addr = 8'd0;

  logic [1:0]  sm, sm_b;
  logic        running, running_b, halted, halted_b, bp_hit, bp_hit_b;
  logic [15:0] cycle_cnt, instr_cnt;
  logic [3:0]  cycle_cnt_b, instr_cnt_b;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 stop, 1 fetch, 2 prep, 3 exec, 4 halt
  int m_st, m_cyc, m_ins;
  bit m_step, m_pend, m_first, m_bp;

  cycle_sequencer #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .sm_en(sm_en), .mem_ready(mem_ready), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .sm(sm), .running(running), .halted(halted), .bp_hit(bp_hit),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  cycle_sequencer #(.ADDR_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .sm_en(sm_en), .mem_ready(mem_ready), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .sm(sm_b), .running(running_b), .halted(halted_b), .bp_hit(bp_hit_b),
    .cycle_cnt(cycle_cnt_b), .instr_cnt(instr_cnt_b)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] sm_code(int s);
    case (s)
      1: return 2'b00;
      2: return 2'b01;
      3: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic int sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_ins = 0;
    m_step = 1'b0; m_pend = 1'b0; m_first = 1'b0; m_bp = 1'b0;
  endtask

  // Apply the rules for one clock edge using the inputs currently driven
  task automatic model_step(output bit done);
    done = 1'b0;
    if (m_st >= 1 && m_st <= 3) begin
      m_cyc++;
      if (stop_req) m_pend = 1'b1;
    end
    case (m_st)
      0: if (step_req || run_req) begin
           m_step = step_req; m_st = 1; m_pend = 1'b0; m_first = 1'b1; m_bp = 1'b0;
         end
      1: if (bp_en && !m_first && pc == bp_addr) begin
           m_st = 0; m_bp = 1'b1;
         end else if (mem_ready) begin
           m_st = 2; m_first = 1'b0;
         end
      2: m_st = 3;
      3: if (!sm_en) begin
           m_st = 4; m_ins++;
         end else if (mem_ready) begin
           m_ins++; done = 1'b1;
           m_st = (m_step || m_pend) ? 0 : 1;
         end
      default: ;
    endcase
  endtask

  // One clock: model advances, DUT sees the edge, pulses drop, pc follows completed instructions
  task automatic tick();
    bit done;
    model_step(done);
    @(posedge clk);
    #1;
    run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
    if (done) pc = pc + 8'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++; if (sm !== 2'b11) begin failures++; $display("FAIL reset_sm got=%b exp=11", sm); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL reset_bp_hit got=%b exp=0", bp_hit); end
    checks++; if (cycle_cnt !== 16'd0) begin failures++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt); end
    checks++; if (instr_cnt !== 16'd0) begin failures++; $display("FAIL reset_instr_cnt got=%0d exp=0", instr_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (sm !== 2'b11) begin failures++; $display("FAIL reset_idle_sm got=%b exp=11", sm); end
  endtask

  task automatic test_step();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'b00, 2'b01, 2'b10, 2'b11};
    do_reset();
    mem_ready = 1'b1; sm_en = 1'b1; bp_en = 1'b0;
    step_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (sm !== exp_seq[i]) begin failures++; $display("FAIL step_sm[%0d] got=%b exp=%b", i, sm, exp_seq[i]); end
    end
    checks++; if (instr_cnt !== 16'd1) begin failures++; $display("FAIL step_instr got=%0d exp=1", instr_cnt); end
    checks++; if (cycle_cnt !== 16'd3) begin failures++; $display("FAIL step_cycle got=%0d exp=3", cycle_cnt); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL step_running got=%b exp=0", running); end
  endtask

  task automatic test_wait_states();
    do_reset();
    sm_en = 1'b1; bp_en = 1'b0;
    run_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sm !== 2'b00) begin failures++; $display("FAIL wait_fetch_hold[%0d] got=%b exp=00", i, sm); end
    end
    mem_ready = 1'b1;
    tick();
    checks++; if (sm !== 2'b01) begin failures++; $display("FAIL wait_prep got=%b exp=01", sm); end
    tick();
    checks++; if (sm !== 2'b10) begin failures++; $display("FAIL wait_exec got=%b exp=10", sm); end
    // Memory wait inside EXEC holds the exec code
    mem_ready = 1'b0;
    tick();
    checks++; if (sm !== 2'b10) begin failures++; $display("FAIL wait_exec_hold got=%b exp=10", sm); end
    mem_ready = 1'b1; stop_req = 1'b1;
    tick();
    checks++; if (sm !== 2'b11) begin failures++; $display("FAIL wait_stop got=%b exp=11", sm); end
    checks++; if (cycle_cnt !== 16'd6) begin failures++; $display("FAIL wait_cycle got=%0d exp=6", cycle_cnt); end
    checks++; if (instr_cnt !== 16'd1) begin failures++; $display("FAIL wait_instr got=%0d exp=1", instr_cnt); end
  endtask

  task automatic test_breakpoint();
    do_reset();
    mem_ready = 1'b1; sm_en = 1'b1;
    pc = 8'h03; bp_en = 1'b1; bp_addr = 8'h05;
    run_req = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (sm !== 2'b11) begin failures++; $display("FAIL bp_stop_sm got=%b exp=11", sm); end
    checks++; if (bp_hit !== 1'b1) begin failures++; $display("FAIL bp_hit got=%b exp=1", bp_hit); end
    checks++; if (instr_cnt !== 16'd2) begin failures++; $display("FAIL bp_instr got=%0d exp=2", instr_cnt); end
    checks++; if (cycle_cnt !== 16'd7) begin failures++; $display("FAIL bp_cycle got=%0d exp=7", cycle_cnt); end
    checks++; if (pc !== 8'h05) begin failures++; $display("FAIL bp_pc got=%h exp=05", pc); end
    run_req = 1'b1;
    tick();
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL bp_clear got=%b exp=0", bp_hit); end
    tick();
    checks++; if (sm !== 2'b01) begin failures++; $display("FAIL bp_resume_prep got=%b exp=01", sm); end
    tick();
    stop_req = 1'b1;
    tick();
    checks++; if (instr_cnt !== 16'd3) begin failures++; $display("FAIL bp_resume_instr got=%0d exp=3", instr_cnt); end
    bp_en = 1'b0;
  endtask

  task automatic test_stop_in_prep();
    do_reset();
    mem_ready = 1'b1; sm_en = 1'b1; bp_en = 1'b0;
    run_req = 1'b1;
    tick();
    tick();
    checks++; if (sm !== 2'b01) begin failures++; $display("FAIL stop_prep_sm got=%b exp=01", sm); end
    stop_req = 1'b1;
    tick();
    checks++; if (sm !== 2'b10) begin failures++; $display("FAIL stop_exec_sm got=%b exp=10", sm); end
    tick();
    checks++; if (sm !== 2'b11) begin failures++; $display("FAIL stop_idle_sm got=%b exp=11", sm); end
    tick();
    checks++; if (instr_cnt !== 16'd1) begin failures++; $display("FAIL stop_instr got=%0d exp=1", instr_cnt); end
    checks++; if (sm !== 2'b11) begin failures++; $display("FAIL stop_stays_sm got=%b exp=11", sm); end
  endtask

  task automatic test_halt();
    do_reset();
    mem_ready = 1'b1; sm_en = 1'b1; bp_en = 1'b0;
    run_req = 1'b1;
    tick(); tick(); tick();
    sm_en = 1'b0; mem_ready = 1'b0;
    tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", halted); end
    checks++; if (sm !== 2'b11) begin failures++; $display("FAIL halt_sm got=%b exp=11", sm); end
    checks++; if (instr_cnt !== 16'd1) begin failures++; $display("FAIL halt_instr got=%0d exp=1", instr_cnt); end
    sm_en = 1'b1; mem_ready = 1'b1;
    run_req = 1'b1; tick();
    step_req = 1'b1; tick();
    tick();
    checks++; if (halted !== 1'b1 || running !== 1'b0) begin
      failures++; $display("FAIL halt_absorb halted=%b running=%b exp=1/0", halted, running);
    end
    checks++; if (cycle_cnt !== 16'd3) begin failures++; $display("FAIL halt_cycle got=%0d exp=3", cycle_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || sm !== 2'b11 || instr_cnt !== 16'd0 || cycle_cnt !== 16'd0) begin
      failures++; $display("FAIL halt_reset halted=%b sm=%b instr=%0d cyc=%0d exp=0/11/0/0", halted, sm, instr_cnt, cycle_cnt);
    end
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    mem_ready = 1'b1; sm_en = 1'b1; bp_en = 1'b0;
    run_req = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (cycle_cnt_b !== 4'(sat(k, 4))) begin
        failures++; $display("FAIL sat_cycle_b[%0d] got=%0d exp=%0d", k, cycle_cnt_b, sat(k, 4));
      end
    end
    checks++; if (cycle_cnt !== 16'd20) begin failures++; $display("FAIL sat_cycle_wide got=%0d exp=20", cycle_cnt); end
    checks++; if (instr_cnt_b !== 4'd6) begin failures++; $display("FAIL sat_instr_b got=%0d exp=6", instr_cnt_b); end
    checks++; if (sm !== 2'b10) begin failures++; $display("FAIL sat_pre_reset_sm got=%b exp=10", sm); end
    // Asynchronous reset in the middle of EXEC: no completion
    rst_n = 1'b0;
    #1;
    checks++; if (sm !== 2'b11 || running !== 1'b0 || instr_cnt !== 16'd0 || cycle_cnt_b !== 4'd0) begin
      failures++; $display("FAIL mid_reset sm=%b running=%b instr=%0d cyc_b=%0d exp=11/0/0/0", sm, running, instr_cnt, cycle_cnt_b);
    end
    do_reset();
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    do_reset();
    pc = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        run_req   = ($urandom_range(0, 7) == 0);
        step_req  = ($urandom_range(0, 9) == 0);
        stop_req  = ($urandom_range(0, 11) == 0);
        mem_ready = ($urandom_range(0, 9) < 7);
        sm_en     = ($urandom_range(0, 399) != 0);
        if ($urandom_range(0, 63) == 0) bp_en = ~bp_en;
        if ($urandom_range(0, 31) == 0) bp_addr = pc + 8'($urandom_range(0, 4));
        if ($urandom_range(0, 99) == 0) pc = 8'($urandom_range(0, 15));
        tick();
      end
      checks++;
      if (sm !== sm_code(m_st) || running !== (m_st >= 1 && m_st <= 3) || halted !== (m_st == 4) ||
          bp_hit !== m_bp) begin
        failures++;
        if (shown < 20) $display("FAIL rand_state[%0d] sm=%b run=%b halt=%b bp=%b exp sm=%b phase=%0d bp=%b",
                                 i, sm, running, halted, bp_hit, sm_code(m_st), m_st, m_bp);
        shown++;
      end
      checks++;
      if (cycle_cnt !== 16'(sat(m_cyc, 16)) || instr_cnt !== 16'(sat(m_ins, 16)) ||
          cycle_cnt_b !== 4'(sat(m_cyc, 4)) || instr_cnt_b !== 4'(sat(m_ins, 4))) begin
        failures++;
        if (shown < 20) $display("FAIL rand_cnt[%0d] cyc=%0d ins=%0d cyc_b=%0d ins_b=%0d exp cyc=%0d ins=%0d",
                                 i, cycle_cnt, instr_cnt, cycle_cnt_b, instr_cnt_b, m_cyc, m_ins);
        shown++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step();
    test_wait_states();
    test_breakpoint();
    test_stop_in_prep();
    test_halt();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
